silence_trim_streamer: RTL and testbench
========================================

// Module: silence_trim_streamer
// PURPOSE
//  Upstream feeder of the DTW core. Accepts a raw 12-bit signed audio stream,
//  splits it into fixed frames, and discards frames whose energy is below a
//  threshold. Voiced frames are kept in an internal buffer. At end of utterance
//  it replays the kept samples, one per clk, on the DTW receive interface
//  (level strobe plus sample bus). One instance feeds the sample port and one
//  feeds the test port.
// PARAMETERS
//  DATA_W    12   sample width, signed two's complement
//  FRAME_LEN 8    samples per energy frame, power of two, >=2
//  MAX_LEN   64   buffer depth in samples, integer multiple of FRAME_LEN
//  THRESH    64   frame kept iff sum(|x|) over the frame >= THRESH
// PORTS
//  clk           in   1       rising-edge clock
//  rst_n         in   1       asynchronous, active-low reset
//  in_valid      in   1       in_sample is accepted on this cycle
//  in_sample     in   DATA_W  signed input sample
//  in_last       in   1       qualifies in_valid; marks last sample of utterance
//  dtw_busy      in   1       downstream busy; replay is held off while high
//  out_active    out  1       receive strobe to DTW; high for exactly out_len cycles
//  out_sample    out  DATA_W  replayed sample, valid while out_active
//  out_len       out  log2(MAX_LEN)+1  kept-sample count; valid from done onward
//  done          out  1       one-cycle pulse after the last replayed sample
//  overflow      out  1       sticky: a voiced frame was dropped because the buffer was full
//  busy          out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; wr_ptr = frame_base = frame_cnt = energy = 0.
//  |x| is computed as unsigned DATA_W bits (|-2048| = 2048).
//  energy width is DATA_W + log2(FRAME_LEN) bits and cannot overflow.
//  IDLE:
//   - in_valid moves the FSM to COLLECT.
//   - That same sample is processed as the first COLLECT sample.
//  COLLECT, for each accepted sample:
//   - Write it to buf[wr_ptr], then increment wr_ptr, energy += |x| and frame_cnt.
//   - Frame end (frame_cnt reaches FRAME_LEN):
//     - Kept frame (energy incl. this sample >= THRESH): frame_base <= wr_ptr+1.
//     - Silent frame: wr_ptr <= frame_base.
//     - In both cases energy and frame_cnt clear.
//   - Full (frame_base == MAX_LEN):
//     - Samples are not written and wr_ptr does not advance.
//     - Energy is still evaluated.
//     - A would-be-kept frame sets overflow.
//   - in_last on a frame-completing sample: that frame is evaluated normally.
//   - in_last mid-frame: the partial frame is discarded (wr_ptr <= frame_base).
//   - After in_last: out_len <= committed length, next state WAIT.
//   - Samples arriving outside COLLECT/IDLE are ignored.
//  WAIT:
//   - Stays while dtw_busy=1.
//   - dtw_busy=0 and length>0: go to STREAM next cycle.
//   - dtw_busy=0 and length==0: go to DONE.
//  STREAM:
//   - out_active=1 and out_sample=buf[rd_ptr], starting at rd_ptr=0.
//   - rd_ptr increments every cycle.
//   - dtw_busy is ignored once streaming has begun.
//   - After out_len cycles, out_active drops and the FSM goes to DONE.
//   - The first out_active cycle is the cycle after WAIT sees dtw_busy=0.
//  DONE:
//   - done=1 for one cycle, then IDLE.
//   - wr_ptr, frame_base and rd_ptr clear.
//   - out_len and overflow hold until the next in_valid in IDLE clears them.
//  rst_n low in any state: immediate return to reset values; buffer contents are don't-care.
//  out_sample is 0 whenever out_active=0.
// TESTING
//  1. Frame 1 all 100, frame 2 all 0 (in_last on sample 16), dtw_busy=0
//     -> out_active 8 cycles of 100, out_len=8, done 1 cycle later.
//  2. Frame of [9,-9,8,-8,8,-8,8,-8] (sum=66)
//     -> kept. Frame of all 7 (sum=56) -> dropped. Signs preserved on replay.
//  3. 9 voiced frames with MAX_LEN=64 -> 64 samples replayed, overflow=1,
//     out_len=64.
//  4. 12 voiced samples then in_last -> partial frame dropped, out_len=8.
//     All-silent utterance -> no out_active, done pulse, out_len=0.
//  5. dtw_busy held high 20 cycles after in_last -> out_active stays 0.
//     It rises the cycle after dtw_busy falls.
//  6. rst_n pulsed low mid-STREAM -> out_active, busy and done 0 immediately.
//     The next utterance then replays correctly.

Source files
------------

// File: rtl/silence_trim_streamer.sv
// Silence-trimming front end for the DTW core.
// Incoming samples are grouped into fixed frames. A frame whose sum of
// magnitudes falls below THRESH is rolled back out of the buffer. When the
// utterance ends, the kept samples are replayed one per clock on the DTW
// receive interface, as soon as the downstream side is no longer busy.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for the first sample of an utterance
// S_COLLECT | buffering samples and scoring frame energy
// S_WAIT    | utterance closed; holding replay while dtw_busy is high
// S_STREAM  | replaying buffered samples, one per clock
// S_DONE    | one-cycle completion pulse, then back to idle
module silence_trim_streamer #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 8,
    parameter int MAX_LEN   = 64,
    parameter int THRESH    = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_sample,
    input  logic                       in_last,
    input  logic                       dtw_busy,
    output logic                       out_active,
    output logic [DATA_W-1:0]          out_sample,
    output logic [$clog2(MAX_LEN):0]   out_len,
    output logic                       done,
    output logic                       overflow,
    output logic                       busy
);

    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int FCNT_W = $clog2(FRAME_LEN);
    localparam int E_W    = DATA_W + FCNT_W;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_WAIT, S_STREAM, S_DONE
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q, frame_base_q, rd_ptr_q, out_len_q;
    logic [FCNT_W-1:0]  frame_cnt_q;
    logic [E_W-1:0]     energy_q;
    logic               out_active_q, done_q, overflow_q, busy_q;
    logic [DATA_W-1:0]  out_sample_q;
    logic [DATA_W-1:0]  mem_q [MAX_LEN];

    logic               accept, full, frame_end, kept, ovf_hit, wr_en;
    logic [DATA_W-1:0]  abs_x;
    logic [E_W-1:0]     energy_d;
    logic [PTR_W-1:0]   wr_ptr_d, frame_base_d;

    // Per-sample scoring: magnitude, running energy, and where the pointers land.
    always_comb begin
        accept       = in_valid && (state_q == S_IDLE || state_q == S_COLLECT);
        full         = (frame_base_q == PTR_W'(MAX_LEN));
        // Magnitude kept unsigned so the most negative sample maps to 2^(DATA_W-1).
        abs_x        = in_sample[DATA_W-1] ? (~in_sample + DATA_W'(1)) : in_sample;
        energy_d     = energy_q + E_W'(abs_x);
        frame_end    = (frame_cnt_q == FCNT_W'(FRAME_LEN - 1));
        kept         = (energy_d >= E_W'(THRESH));
        wr_ptr_d     = full ? wr_ptr_q : wr_ptr_q + PTR_W'(1);
        frame_base_d = frame_base_q;
        if (frame_end) begin
            if (kept) begin
                if (!full) frame_base_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = frame_base_q;
            end
        end else if (in_last) begin
            // A trailing partial frame is never committed.
            wr_ptr_d = frame_base_q;
        end
        ovf_hit = frame_end && kept && full;
        wr_en   = accept && !full;
    end

    // Sample buffer; contents are don't-care after reset so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_sample;
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            frame_base_q <= '0;
            rd_ptr_q     <= '0;
            out_len_q    <= '0;
            frame_cnt_q  <= '0;
            energy_q     <= '0;
            out_active_q <= 1'b0;
            out_sample_q <= '0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_COLLECT: begin
                    if (in_valid) begin
                        wr_ptr_q     <= wr_ptr_d;
                        frame_base_q <= frame_base_d;
                        energy_q     <= (frame_end || in_last) ? '0 : energy_d;
                        frame_cnt_q  <= (frame_end || in_last) ? '0 : frame_cnt_q + FCNT_W'(1);
                        // Sticky flag restarts with each new utterance.
                        overflow_q   <= ((state_q == S_COLLECT) && overflow_q) || ovf_hit;
                        busy_q       <= 1'b1;
                        if (in_last) begin
                            out_len_q <= frame_base_d;
                            state_q   <= S_WAIT;
                        end else begin
                            if (state_q == S_IDLE) out_len_q <= '0;
                            state_q <= S_COLLECT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!dtw_busy) begin
                        if (out_len_q != '0) begin
                            out_active_q <= 1'b1;
                            out_sample_q <= mem_q[0];
                            rd_ptr_q     <= PTR_W'(1);
                            state_q      <= S_STREAM;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (rd_ptr_q == out_len_q) begin
                        out_active_q <= 1'b0;
                        out_sample_q <= '0;
                        done_q       <= 1'b1;
                        state_q      <= S_DONE;
                    end else begin
                        out_sample_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
                        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
                    end
                end
                S_DONE: begin
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    wr_ptr_q     <= '0;
                    frame_base_q <= '0;
                    rd_ptr_q     <= '0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_active = out_active_q;
    assign out_sample = out_sample_q;
    assign out_len    = out_len_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_silence_trim_streamer.sv
// Directed bench for silence_trim_streamer: a table of two-frame utterances
// with hand-computed kept frames, plus hand-written sequences for overflow,
// downstream back-pressure and reset during replay.
module tb_silence_trim_streamer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_sample = '0;
    logic        in_last = 1'b0;
    logic        dtw_busy = 1'b0;
    logic        out_active;
    logic [11:0] out_sample;
    logic [6:0]  out_len;
    logic        done;
    logic        overflow;
    logic        busy;

    silence_trim_streamer #(
        .DATA_W(12), .FRAME_LEN(8), .MAX_LEN(64), .THRESH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sample(in_sample),
        .in_last(in_last), .dtw_busy(dtw_busy), .out_active(out_active),
        .out_sample(out_sample), .out_len(out_len), .done(done),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef logic [7:0][11:0] frame_t;
    typedef struct {
        frame_t     fa;
        frame_t     fb;
        int         n;
        int         len;
        logic [1:0] mask;
    } vec_t;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [11:0] exp_q[$];
    vec_t        vecs[9];

    function automatic frame_t rep(input int v);
        frame_t r;
        for (int i = 0; i < 8; i++) r[i] = 12'(v);
        return r;
    endfunction

    function automatic frame_t mk(input int a0, input int a1, input int a2, input int a3,
                                  input int a4, input int a5, input int a6, input int a7);
        frame_t r;
        r[0] = 12'(a0); r[1] = 12'(a1); r[2] = 12'(a2); r[3] = 12'(a3);
        r[4] = 12'(a4); r[5] = 12'(a5); r[6] = 12'(a6); r[7] = 12'(a7);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic send(input logic [11:0] s, input logic last);
        @(negedge clk);
        in_valid  = 1'b1;
        in_sample = s;
        in_last   = last;
    endtask

    task automatic finish_send();
        @(negedge clk);
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_sample = '0;
    endtask

    task automatic send_vec(input int i);
        exp_q.delete();
        for (int j = 0; j < 8; j++) if (vecs[i].mask[0]) exp_q.push_back(vecs[i].fa[j]);
        for (int j = 0; j < 8; j++) if (vecs[i].mask[1]) exp_q.push_back(vecs[i].fb[j]);
        for (int s = 0; s < vecs[i].n; s++)
            send(s < 8 ? vecs[i].fa[s] : vecs[i].fb[s-8], s == vecs[i].n - 1);
        finish_send();
    endtask

    // Observe replay until done, comparing against exp_q.
    task automatic monitor(input int exp_len, input int exp_ovf, input int busy_cycles,
                           input bit rebusy, input string tag);
        int k = 0;
        bit seen_done = 0;
        bit first = 1;
        bit prev_active = 0;
        repeat (busy_cycles) begin
            @(negedge clk);
            check({tag, " held off"}, int'(out_active), 0);
            check({tag, " busy while held"}, int'(busy), 1);
        end
        dtw_busy = 1'b0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            @(negedge clk);
            if (first) begin
                check({tag, " first active"}, int'(out_active), int'(exp_len > 0));
                first = 0;
            end
            if (out_active) begin
                if (k < exp_q.size())
                    check($sformatf("%s sample%0d", tag, k), int'($signed(out_sample)),
                          int'($signed(exp_q[k])));
                else
                    check({tag, " extra sample"}, 1, 0);
                k++;
                if (rebusy && k == 1) dtw_busy = 1'b1;
            end else begin
                check({tag, " idle sample zero"}, int'(out_sample), 0);
            end
            if (done) begin
                seen_done = 1;
                check({tag, " active count"}, k, exp_len);
                check({tag, " out_len"}, int'(out_len), exp_len);
                check({tag, " overflow"}, int'(overflow), exp_ovf);
                if (exp_len > 0) check({tag, " done after last"}, int'(prev_active), 1);
            end
            prev_active = out_active;
        end
        if (!seen_done) check({tag, " done timeout"}, 0, 1);
        @(negedge clk);
        check({tag, " done one cycle"}, int'(done), 0);
        check({tag, " idle busy"}, int'(busy), 0);
        check({tag, " out_len held"}, int'(out_len), exp_len);
        check({tag, " overflow held"}, int'(overflow), exp_ovf);
        dtw_busy = 1'b0;
    endtask

    initial begin
        vecs[0] = '{rep(100), rep(0), 16, 8, 2'b01};
        vecs[1] = '{mk(9,-9,8,-8,8,-8,8,-8), rep(7), 16, 8, 2'b01};
        vecs[2] = '{rep(7), mk(9,-9,8,-8,8,-8,8,-8), 16, 8, 2'b10};
        vecs[3] = '{rep(8), mk(8,8,8,8,8,8,8,7), 16, 8, 2'b01};
        vecs[4] = '{rep(50), rep(50), 12, 8, 2'b01};
        vecs[5] = '{rep(1), rep(-1), 16, 0, 2'b00};
        vecs[6] = '{mk(-2048,0,0,0,0,0,0,0), mk(5,-5,5,-5,5,-5,5,-5), 16, 8, 2'b01};
        vecs[7] = '{rep(-30), rep(10), 16, 16, 2'b11};
        vecs[8] = '{rep(100), rep(0), 7, 0, 2'b00};

        repeat (3) @(negedge clk);
        check("reset out_active", int'(out_active), 0);
        check("reset out_sample", int'(out_sample), 0);
        check("reset out_len", int'(out_len), 0);
        check("reset done", int'(done), 0);
        check("reset overflow", int'(overflow), 0);
        check("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            send_vec(i);
            monitor(vecs[i].len, 0, 0, 0, $sformatf("vec%0d", i));
        end

        // Back-pressure: held for 20 cycles, then busy re-asserted mid-replay.
        dtw_busy = 1'b1;
        send_vec(0);
        monitor(8, 0, 20, 1, "backpressure");

        // Nine voiced frames into a 64-sample buffer: ninth is dropped.
        exp_q.delete();
        for (int f = 0; f < 9; f++)
            for (int j = 0; j < 8; j++) begin
                send(12'(100 + f), f == 8 && j == 7);
                if (f < 8) exp_q.push_back(12'(100 + f));
            end
        finish_send();
        monitor(64, 1, 0, 0, "overflow");
        send_vec(0);
        monitor(8, 0, 0, 0, "after overflow");

        // Reset during replay, then a clean utterance.
        send_vec(7);
        for (int c = 0; c < 50 && !out_active; c++) @(negedge clk);
        check("rst pre active", int'(out_active), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst out_active", int'(out_active), 0);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst out_len", int'(out_len), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_vec(1);
        monitor(8, 0, 0, 0, "post reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
